// File: rtl/bits_imem_controller_if.sv
// Instruction-fetch handshake between the BITS core / I-cache (master) and the
// instruction memory controller (slave).
//   mem_req_b              master -> slave  active-low word request (level)
//   mem_ack_b              slave -> master  active-low one-cycle ack
//   instruction_word       slave -> master  128-bit word, first byte in [127:120]
//   instruction_byte_valid slave -> master  MSB-first thermometer of valid bytes
//   done_reading_memory    slave -> master  sticky end-of-stream flag
interface bits_imem_controller_if;
  logic         mem_req_b;
  logic         mem_ack_b;
  logic [127:0] instruction_word;
  logic [15:0]  instruction_byte_valid;
  logic         done_reading_memory;

  modport master (
    output mem_req_b,
    input  mem_ack_b,
    input  instruction_word,
    input  instruction_byte_valid,
    input  done_reading_memory
  );

  modport slave (
    input  mem_req_b,
    output mem_ack_b,
    output instruction_word,
    output instruction_byte_valid,
    output done_reading_memory
  );
endinterface

// File: rtl/bits_imem_controller.sv
// Responder end of the BITS instruction-fetch handshake. Reads the packed hex
// transmission from a 32-bit instruction SRAM (1-cycle read latency, byte [31:24]
// first), assembles up to four words into a 128-bit instruction word with an
// MSB-first byte-valid thermometer, and flags end-of-stream once all expected
// bytes have been acknowledged.
//
// Optional feature macro: IMEM_PREFETCH_EN
//   defined   - after each ack the next word is fetched into the assembly buffer
//               without waiting for a request; a request then acks from it.
//   undefined - fetch strictly on request.
//
// Ports:
//   clk               system clock
//   resetB            synchronous active-low reset
//   start_i           pulse: latch expected_bytes_i, restart from BASE_ADDR
//   expected_bytes_i  total bytes in the transmission
//   bus               handshake interface (slave modport)
//   imem_ceb_o        active-low SRAM chip enable (read only)
//   imem_addr_o       SRAM word address
//   imem_rdata_i      SRAM read data
module bits_imem_controller #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       resetB,
  input  logic                       start_i,
  input  logic [15:0]                expected_bytes_i,
  bits_imem_controller_if.slave      bus,
  output logic                       imem_ceb_o,
  output logic [ADDR_W-1:0]          imem_addr_o,
  input  logic [31:0]                imem_rdata_i
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StAck,
    StHold,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         remaining_q, remaining_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [2:0]          fetch_cnt_q, fetch_cnt_d;
  logic [1:0]          lane_q, lane_d;
  logic                rd_valid_q, rd_valid_d;
  logic [127:0]        buf_q, buf_d;
  logic [127:0]        word_q, word_d;
  logic [15:0]         valid_q, valid_d;
`ifdef IMEM_PREFETCH_EN
  // Set once the consumer has asked for the word currently being fetched.
  logic                pend_q, pend_d;
`endif

  logic [15:0]  take;
  logic [15:0]  rem_after;
  logic [15:0]  therm;
  logic [2:0]   num_words;
  logic [127:0] byte_mask;
  logic         issue;
  logic         go_ack;

  // Bytes delivered by the next ack and the SRAM words needed to cover them.
  assign take      = (remaining_q > 16'd16) ? 16'd16 : remaining_q;
  assign rem_after = remaining_q - take;
  assign therm     = ~(16'hFFFF >> take);
  assign num_words = (remaining_q > 16'd15) ? 3'd4
                   : ({1'b0, remaining_q[3:2]} + {2'b00, |remaining_q[1:0]});

  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < 16; i++) begin
      byte_mask[8*i +: 8] = {8{therm[i]}};
    end
  end

  // start gates the enable combinationally so an aborting cycle never reads.
  assign issue       = (state_q == StFetch) && !start_i;
  assign imem_ceb_o  = !issue;
  assign imem_addr_o = ADDR_W'(BASE_ADDR) + rd_ptr_q;

  assign bus.mem_ack_b              = (state_q != StAck);
  assign bus.instruction_word       = word_q;
  assign bus.instruction_byte_valid = valid_q;
  assign bus.done_reading_memory    = (state_q == StDone);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    rd_ptr_d    = rd_ptr_q;
    fetch_cnt_d = fetch_cnt_q;
    lane_d      = lane_q;
    rd_valid_d  = issue;
    buf_d       = buf_q;
    word_d      = word_q;
    valid_d     = valid_q;
    go_ack      = 1'b0;
`ifdef IMEM_PREFETCH_EN
    pend_d      = pend_q;
`endif

    // Read data lands one cycle after the enable; fill lanes MSB first.
    if (rd_valid_q) begin
      unique case (lane_q)
        2'd0: buf_d[127:96] = imem_rdata_i;
        2'd1: buf_d[95:64]  = imem_rdata_i;
        2'd2: buf_d[63:32]  = imem_rdata_i;
        2'd3: buf_d[31:0]   = imem_rdata_i;
        default: ;
      endcase
      lane_d = lane_q + 2'd1;
    end

    if (start_i) begin
      state_d     = (expected_bytes_i == 16'd0) ? StDone : StIdle;
      remaining_d = expected_bytes_i;
      rd_ptr_d    = '0;
      rd_valid_d  = 1'b0;
`ifdef IMEM_PREFETCH_EN
      pend_d      = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // remaining==0 here only straight out of reset: wait for a start.
          if (!bus.mem_req_b && remaining_q != 16'd0) begin
            state_d     = StFetch;
            fetch_cnt_d = '0;
            lane_d      = '0;
`ifdef IMEM_PREFETCH_EN
            pend_d      = 1'b1;
`endif
          end
        end
        StFetch: begin
          rd_ptr_d    = rd_ptr_q + 1'b1;
          fetch_cnt_d = fetch_cnt_q + 3'd1;
          if (fetch_cnt_q + 3'd1 == num_words) state_d = StCapture;
`ifdef IMEM_PREFETCH_EN
          if (!bus.mem_req_b) pend_d = 1'b1;
`endif
        end
        StCapture: begin
`ifdef IMEM_PREFETCH_EN
          if (pend_q || !bus.mem_req_b) go_ack = 1'b1;
          else                          state_d = StHold;
`else
          go_ack = 1'b1;
`endif
        end
        StHold: begin
          if (!bus.mem_req_b) go_ack = 1'b1;
        end
        StAck: begin
          remaining_d = rem_after;
          if (rem_after == 16'd0) begin
            state_d = StDone;
          end else if (!bus.mem_req_b) begin
            // Request still held: chain straight into the next fetch.
            state_d     = StFetch;
            fetch_cnt_d = '0;
            lane_d      = '0;
`ifdef IMEM_PREFETCH_EN
            pend_d      = 1'b1;
`endif
          end else begin
`ifdef IMEM_PREFETCH_EN
            state_d     = StFetch;
            fetch_cnt_d = '0;
            lane_d      = '0;
            pend_d      = 1'b0;
`else
            state_d     = StIdle;
`endif
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase

      if (go_ack) begin
        state_d = StAck;
        word_d  = buf_d & byte_mask;
        valid_d = therm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetB) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      rd_ptr_q    <= '0;
      fetch_cnt_q <= '0;
      lane_q      <= '0;
      rd_valid_q  <= 1'b0;
      buf_q       <= '0;
      word_q      <= '0;
      valid_q     <= '0;
`ifdef IMEM_PREFETCH_EN
      pend_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      rd_ptr_q    <= rd_ptr_d;
      fetch_cnt_q <= fetch_cnt_d;
      lane_q      <= lane_d;
      rd_valid_q  <= rd_valid_d;
      buf_q       <= buf_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
`ifdef IMEM_PREFETCH_EN
      pend_q      <= pend_d;
`endif
    end
  end

endmodule
